// File: rtl/matmul_pkg.sv
// Shared constants, widths and engine state encoding for the 4x4 Q8.8 matrix
// multiplier behind an Avalon-MM slave port.
package matmul_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 35;
  localparam int RES_W  = 32;

  localparam logic [5:0] CTRL   = 6'h00;
  localparam logic [5:0] STATUS = 6'h01;
  localparam logic [5:0] A_BASE = 6'h10;
  localparam logic [5:0] B_BASE = 6'h20;
  localparam logic [5:0] C_BASE = 6'h30;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/matmul_mac_sat.sv
// One multiply-accumulate step plus clamp of the running sum to the signed
// 32-bit result range; purely combinational around the registered accumulator.
module matmul_mac_sat
  import matmul_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  sum,
  output logic signed [RES_W-1:0]  sat
);

  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    prod = a * b;
    sum  = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // The sum fits when every bit above the result sign bit copies it.
    if (sum[ACC_W-1:RES_W-1] == {(ACC_W-RES_W+1){sum[RES_W-1]}})
      sat = sum[RES_W-1:0];
    else if (sum[ACC_W-1])
      sat = {1'b1, {(RES_W-1){1'b0}}};
    else
      sat = {1'b0, {(RES_W-1){1'b1}}};
  end

endmodule

// File: rtl/matmul_avs_slave.sv
// Avalon-MM slave holding A, B and C matrices, control/status registers and
// the IDLE/RUN engine that computes C = A*B one MAC per cycle.
module matmul_avs_slave
  import matmul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        irq
);

  state_t                    state;
  logic                      busy;
  logic                      done;
  logic                      irq_en;
  logic [1:0]                i, j, k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [RES_W-1:0]   c_sat;
  logic signed [DATA_W-1:0]  a_mem [N*N];
  logic signed [DATA_W-1:0]  b_mem [N*N];
  logic signed [RES_W-1:0]   c_mem [N*N];
  logic [31:0]               rdata;
  logic [3:0]                idx;
  logic                      wr_ctrl;
  logic                      unused_wdata;

  assign busy         = (state == RUN);
  assign idx          = avs_address[3:0];
  assign wr_ctrl      = avs_write && (avs_address == CTRL);
  assign unused_wdata = ^avs_writedata[31:16];

  matmul_mac_sat u_mac (
    .a   (a_mem[{i, k}]),
    .b   (b_mem[{k, j}]),
    .acc (acc),
    .sum (acc_next),
    .sat (c_sat)
  );

  always_comb begin
    rdata = '0;
    case (avs_address[5:4])
      A_BASE[5:4]: rdata = {{(32-DATA_W){a_mem[idx][DATA_W-1]}}, a_mem[idx]};
      B_BASE[5:4]: rdata = {{(32-DATA_W){b_mem[idx][DATA_W-1]}}, b_mem[idx]};
      C_BASE[5:4]: rdata = c_mem[idx];
      default: begin
        if (avs_address == CTRL)        rdata[CTRL_IRQ_EN] = irq_en;
        else if (avs_address == STATUS) rdata[1:0] = {done, busy};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      done              <= 1'b0;
      irq_en            <= 1'b0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      {i, j, k}         <= '0;
      acc               <= '0;
      // NOTE: the matrices must read back as zero after reset, so every entry
      // is cleared here; this keeps them in flops rather than block RAM.
      for (int n = 0; n < N*N; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
    end else begin
      // NOTE: all state here uses non-blocking assignments so every read in
      // this block sees the pre-edge value regardless of statement order.
      avs_readdatavalid <= avs_read;
      avs_readdata      <= rdata;
      irq               <= done & irq_en;

      if (wr_ctrl) irq_en <= avs_writedata[CTRL_IRQ_EN];
      if (wr_ctrl && avs_writedata[CTRL_CLR_DONE]) done <= 1'b0;

      if (avs_write && !busy) begin
        if (avs_address[5:4] == A_BASE[5:4]) a_mem[idx] <= avs_writedata[DATA_W-1:0];
        if (avs_address[5:4] == B_BASE[5:4]) b_mem[idx] <= avs_writedata[DATA_W-1:0];
      end

      case (state)
        IDLE: begin
          if (wr_ctrl && avs_writedata[CTRL_START]) begin
            state     <= RUN;
            done      <= 1'b0;
            {i, j, k} <= '0;
            acc       <= '0;
          end
        end
        RUN: begin
          if (k == 2'd3) begin
            c_mem[{i, j}] <= c_sat;
            acc           <= '0;
          end else begin
            acc <= acc_next;
          end
          {i, j, k} <= {i, j, k} + 6'd1;
          // Completion is ordered after clr_done so a finishing run always flags done.
          if ({i, j, k} == 6'h3F) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_avs_slave.sv
// Scoreboard bench for matmul_avs_slave: reads push expected data, a negedge
// monitor pops and compares each readdatavalid response and its latency.
module tb_matmul_avs_slave;
  import matmul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;

  matmul_avs_slave #(.N(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int last_wr  = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Each response must arrive exactly one cycle after its read was issued.
  always @(negedge clk) begin
    exp_t e;
    if (avs_readdatavalid) begin
      if (sb.size() == 0) begin
        check("unexpected_readdatavalid", 32'(avs_readdatavalid), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_latency"}, 32'(cyc - e.cyc), 32'd1);
        check(e.name, avs_readdata, e.data);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc + 1) begin
      e = sb.pop_front();
      check({e.name, "_missing_valid"}, 32'(avs_readdatavalid), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    last_wr       = cyc;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.data = exp;
    e.cyc  = cyc;
    e.name = name;
    sb.push_back(e);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  // Start a run and confirm busy through t+64 and done at t+65.
  task automatic run_timed(input logic [31:0] ctrl, input string tag);
    int t;
    wr(CTRL, ctrl);
    t = last_wr;
    rd(STATUS, 32'h1, {tag, "_busy_t1"});
    wait_to(t + 64);
    rd(STATUS, 32'h1, {tag, "_busy_t64"});
    rd(STATUS, 32'h2, {tag, "_done_t65"});
  endtask

  task automatic read_all_c(input logic [31:0] step, input logic [31:0] base, input string tag);
    for (int n = 0; n < 16; n++)
      rd(C_BASE + 6'(n), base + step * 32'(n), $sformatf("%s_c%0d", tag, n));
  endtask

  initial begin
    int t;
    reset         = 1'b1;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_address   = '0;
    avs_writedata = '0;
    idle(3);
    check("rst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset = 1'b0;
    rd(STATUS, 32'h0, "rst_status");
    rd(CTRL, 32'h0, "rst_ctrl");
    rd(A_BASE, 32'h0, "rst_a0");
    rd(B_BASE + 6'd15, 32'h0, "rst_b15");
    rd(C_BASE + 6'd5, 32'h0, "rst_c5");

    // Identity A times scaled B gives C[n] = 0x10000*(n+1).
    for (int n = 0; n < 16; n++) wr(A_BASE + 6'(n), (n % 5 == 0) ? 32'h0100 : 32'h0);
    for (int n = 0; n < 16; n++) wr(B_BASE + 6'(n), 32'(256 * (n + 1)));
    wr(CTRL, 32'h4);
    rd(CTRL, 32'h4, "ctrl_irq_en");
    rd(B_BASE + 6'd15, 32'h1000, "b15_readback");
    run_timed(32'h5, "ident");
    check("ident_irq", 32'(irq), 32'd1);
    read_all_c(32'h10000, 32'h10000, "ident");

    // Start and A write during a run are both ignored.
    wr(CTRL, 32'h5);
    t = last_wr;
    wait_to(t + 10);
    wr(CTRL, 32'h5);
    wait_to(t + 20);
    wr(A_BASE + 6'd1, 32'h1234);
    wait_to(t + 64);
    rd(STATUS, 32'h1, "rebusy_busy_t64");
    rd(STATUS, 32'h2, "rebusy_done_t65");
    rd(A_BASE + 6'd1, 32'h0, "rebusy_a1_unchanged");
    read_all_c(32'h10000, 32'h10000, "rebusy");

    // Positive and negative saturation.
    for (int n = 0; n < 16; n++) wr(A_BASE + 6'(n), 32'h7FFF);
    for (int n = 0; n < 16; n++) wr(B_BASE + 6'(n), 32'h7FFF);
    run_timed(32'h5, "satp");
    read_all_c(32'h0, 32'h7FFF_FFFF, "satp");
    for (int n = 0; n < 16; n++) wr(A_BASE + 6'(n), 32'h8000);
    rd(A_BASE + 6'd3, 32'hFFFF_8000, "a3_sign_ext");
    run_timed(32'h5, "satn");
    read_all_c(32'h0, 32'h8000_0000, "satn");

    // Reset mid-run, with a read in the reset cycle that must not answer.
    wr(CTRL, 32'h5);
    t = last_wr;
    wait_to(t + 30);
    reset       = 1'b1;
    avs_address = C_BASE;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    avs_read = 1'b0;
    check("midrst_irq", 32'(irq), 32'd0);
    rd(STATUS, 32'h0, "midrst_status");
    rd(CTRL, 32'h0, "midrst_ctrl");
    read_all_c(32'h0, 32'h0, "midrst");

    // Signed operands, back-to-back reads, unmapped addresses.
    wr(A_BASE, 32'hFF80);
    wr(A_BASE + 6'd15, 32'h0200);
    wr(B_BASE + 6'd15, 32'hFF00);
    wr(6'h05, 32'hDEAD_BEEF);
    run_timed(32'h1, "signed");
    rd(STATUS, 32'h2, "bb_status");
    rd(A_BASE, 32'hFFFF_FF80, "bb_a0");
    rd(6'h3F, 32'hFFFE_0000, "bb_c15");
    rd(6'h05, 32'h0, "unmapped_05");
    rd(6'h0F, 32'h0, "unmapped_0f");
    rd(C_BASE, 32'h0, "signed_c0");
    check("irq_disabled", 32'(irq), 32'd0);

    // irq_en gates irq without touching done.
    wr(CTRL, 32'h4);
    idle(1);
    check("irq_enabled", 32'(irq), 32'd1);
    rd(STATUS, 32'h2, "irq_en_keeps_done");
    wr(CTRL, 32'h0);
    idle(1);
    check("irq_masked", 32'(irq), 32'd0);
    rd(STATUS, 32'h2, "irq_dis_keeps_done");

    // start together with clr_done while done is set.
    wr(CTRL, 32'h3);
    t = last_wr;
    rd(STATUS, 32'h1, "start_clr_status");
    wait_to(t + 65);
    rd(STATUS, 32'h2, "start_clr_done_t65");
    wr(CTRL, 32'h2);
    rd(STATUS, 32'h0, "clr_done_status");

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_avs_slave.md
MATMUL_AVS_SLAVE -- requirements
Module: matmul_avs_slave

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock for all logic.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port avs_address, input, 6 bits: Avalon-MM word address from the HPS lightweight bridge.
REQ-004 SHALL have port avs_read, input, 1 bit: read request.
REQ-005 SHALL have port avs_write, input, 1 bit: write request.
REQ-006 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-007 SHALL have port avs_readdata, output, 32 bits: read data, valid only while avs_readdatavalid is high.
REQ-008 SHALL have port avs_readdatavalid, output, 1 bit: read response strobe.
REQ-009 SHALL have port irq, output, 1 bit: level interrupt to the HPS.
REQ-010 SHALL have parameter N, default 4, meaning: square matrix dimension; only 4 is supported.

Function
REQ-011 Address map SHALL be:
- 0x00 CTRL (R/W): bit0 start (write-1 pulse, reads 0), bit1 clr_done (write-1 pulse, reads 0), bit2 irq_en (persistent).
- 0x01 STATUS (RO): bit0 busy, bit1 done.
- 0x10-0x1F A[i][j], row-major, R/W, stored in [15:0] as signed Q8.8.
- 0x20-0x2F B, same layout as A.
- 0x30-0x3F C, RO, 32-bit signed.
- All other addresses: reads return 0, writes are ignored.
REQ-012 Read latency SHALL be exactly 1 cycle: a read accepted at cycle t gives avs_readdatavalid=1 at t+1 only. There is no waitrequest; every access is accepted the cycle it is presented.
REQ-013 A/B reads SHALL return the stored value sign-extended to 32 bits.
REQ-014 While busy, writes to A or B SHALL be ignored.
REQ-015 While busy, reads of C SHALL return the current stored contents: either the previous result or the entry already written by the current run.
REQ-016 Engine FSM states SHALL be IDLE and RUN.
- IDLE -> RUN when a start write is seen with busy=0.
- RUN -> IDLE after the 64th MAC cycle.
- A start write while busy SHALL be ignored.
REQ-017 In RUN the engine SHALL perform one MAC per cycle.
- Counters i, j, k are 2 bits each; k runs innermost, then j, then i.
- Each cycle: acc <= acc + A[i][k]*B[k][j], with a 16x16 signed product and a 35-bit accumulator.
REQ-018 When k==3, C[i][j] SHALL be written with (acc + product) saturated to the signed 32-bit range [0x80000000, 0x7FFFFFFF], and acc SHALL clear to 0.
REQ-019 Timing for a start write at cycle t:
- busy=1 from t+1 through t+64.
- busy=0 and done=1 at t+65.
- C[3][3] is valid at t+65.
REQ-020 irq SHALL equal done AND irq_en, registered.
REQ-021 done SHALL clear on clr_done, and also on an accepted start.
REQ-022 A write with both start and clr_done set while idle SHALL give done=0 and busy=1 on the next cycle.
REQ-023 Changing irq_en SHALL not affect done.

Reset
REQ-024 On reset the following SHALL be 0:
- avs_readdata, avs_readdatavalid, irq
- busy, done, irq_en
- i, j, k, acc
- all A, B and C entries
REQ-025 A reset asserted during RUN SHALL abort the run within the same cycle. The next cycle SHALL be IDLE with C all zero.
REQ-026 A read accepted in the reset cycle SHALL produce no readdatavalid.

Structure
REQ-027 A shared package matmul_pkg SHALL hold:
- address constants: CTRL, STATUS, A_BASE, B_BASE, C_BASE
- CTRL bit indices
- the FSM state enum
- widths: DATA_W=16, ACC_W=35, RES_W=32
REQ-028 The MAC and saturation datapath SHALL be one sub-module, matmul_mac_sat, which is combinational with acc as a registered input. Register file and FSM SHALL stay in the top.

Verification
REQ-029 Identity:
- Stimulus: A=I (0x0100 on the diagonal), B[i][j]=0x0100*(4i+j+1), then start.
- Response: C[i][j]=0x10000*(4i+j+1); done at start+65; irq=1 with irq_en=1.
REQ-030 Positive saturation:
- Stimulus: all A and B = 0x7FFF.
- Response: every C = 0x7FFFFFFF.
- Stimulus: all A = 0x8000, all B = 0x7FFF.
- Response: every C = 0x80000000.
REQ-031 Start while busy:
- Stimulus: a second start at start+10, and an A write at start+20.
- Response: done still at the original start+65; A unchanged; result unchanged.
REQ-032 Reset mid-run:
- Stimulus: assert reset at start+30.
- Response: next cycle busy=0, done=0, C all 0, irq=0.
REQ-033 Read timing:
- Stimulus: back-to-back reads of 0x01, 0x10, 0x3F.
- Response: each readdatavalid exactly 1 cycle after its read with the correct data; a read of 0x05 returns 0.
- Stimulus: start+clr_done write while done=1.
- Response: done=0 and busy=1 the next cycle.
